// File: rtl/led_color_fader_if.sv
// Avalon-MM slave bus bundle for the LED color fader register file.
interface led_color_fader_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_color_fader.sv
// Owns the live RGB color for the LED driver and ramps it toward a software
// target in timed linear steps, flagging completion with a sticky done bit.
module led_color_fader #(
    parameter logic [15:0] RESET_PERIOD = 16'd50000,
    parameter logic [7:0]  RESET_STEP   = 8'd1
) (
    input  logic               clk,
    input  logic               reset,
    led_color_fader_if.slave   bus,
    output logic [23:0]        out_port,
    output logic               irq
);
    typedef enum logic {ST_IDLE = 1'b0, ST_FADING = 1'b1} state_t;

    logic [23:0] live_r, target_r;
    logic [15:0] period_r, cnt_r;
    logic [7:0]  step_r;
    logic        done_r, irq_en_r, irq_r;

    state_t      state_s;
    logic        wr_s, wr_target_s, wr_period_s, wr_step_s, wr_ctrl_s, snap_s, tick_s;
    logic        done_set_s, done_nxt_s, irq_en_nxt_s;
    logic [15:0] period_eff_s, cnt_nxt_s;
    logic [7:0]  step_eff_s;
    logic [23:0] stepped_s, live_nxt_s;
    logic        unused_s;

    // Move one channel toward its target by stp, clamping at the target (9-bit math).
    function automatic logic [7:0] chan_step(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] stp);
        logic [8:0] up;
        logic [8:0] dn;
        logic [7:0] res;
        up = {1'b0, cur} + {1'b0, stp};
        dn = {1'b0, cur} - {1'b0, stp};
        if (cur < tgt) begin
            res = (up > {1'b0, tgt}) ? tgt : up[7:0];
        end else if (cur > tgt) begin
            res = (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign unused_s = ^bus.writedata[31:24];

    // Bus decode, effective period/step and the fade state derived from live vs target
    always_comb begin
        wr_s         = bus.chipselect & ~bus.write_n;
        wr_target_s  = wr_s && (bus.address == 2'd0);
        wr_period_s  = wr_s && (bus.address == 2'd1);
        wr_step_s    = wr_s && (bus.address == 2'd2);
        wr_ctrl_s    = wr_s && (bus.address == 2'd3);
        snap_s       = wr_ctrl_s & bus.writedata[3];
        period_eff_s = (period_r == 16'd0) ? 16'd1 : period_r;
        step_eff_s   = (step_r == 8'd0) ? 8'd1 : step_r;
        state_s      = (live_r != target_r) ? ST_FADING : ST_IDLE;
    end

    // Next live color, tick counter and done/irq_en updates
    always_comb begin
        stepped_s  = {chan_step(live_r[23:16], target_r[23:16], step_eff_s),
                      chan_step(live_r[15:8],  target_r[15:8],  step_eff_s),
                      chan_step(live_r[7:0],   target_r[7:0],   step_eff_s)};
        tick_s     = (cnt_r >= (period_eff_s - 16'd1));
        live_nxt_s = live_r;
        cnt_nxt_s  = 16'd0;
        done_set_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                live_nxt_s = live_r;
                cnt_nxt_s  = 16'd0;
            end
            ST_FADING: begin
                // Snap and retarget both restart timing and pre-empt a step on this edge
                if (snap_s) begin
                    live_nxt_s = target_r;
                    done_set_s = 1'b1;
                end else if (wr_target_s) begin
                    cnt_nxt_s = 16'd0;
                end else if (tick_s) begin
                    live_nxt_s = stepped_s;
                    done_set_s = (stepped_s == target_r);
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                live_nxt_s = live_r;
                cnt_nxt_s  = 16'd0;
            end
        endcase

        if (done_set_s) begin
            done_nxt_s = 1'b1;
        end else if (wr_ctrl_s && bus.writedata[1]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        irq_en_nxt_s = wr_ctrl_s ? bus.writedata[2] : irq_en_r;
    end

    // Register file, live color and tick counter
    always_ff @(posedge clk) begin
        if (reset) begin
            live_r   <= 24'd0;
            target_r <= 24'd0;
            period_r <= RESET_PERIOD;
            step_r   <= RESET_STEP;
            cnt_r    <= 16'd0;
            done_r   <= 1'b0;
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            live_r   <= live_nxt_s;
            cnt_r    <= cnt_nxt_s;
            done_r   <= done_nxt_s;
            irq_en_r <= irq_en_nxt_s;
            irq_r    <= done_nxt_s & irq_en_nxt_s;
            if (wr_target_s) begin
                target_r <= bus.writedata[23:0];
            end
            if (wr_period_s) begin
                period_r <= bus.writedata[15:0];
            end
            if (wr_step_s) begin
                step_r <= bus.writedata[7:0];
            end
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        case (bus.address)
            2'd0:    bus.readdata = {8'd0, live_r};
            2'd1:    bus.readdata = {16'd0, period_r};
            2'd2:    bus.readdata = {24'd0, step_r};
            2'd3:    bus.readdata = {28'd0, 1'b0, irq_en_r, done_r, (state_s == ST_FADING)};
            default: bus.readdata = 32'd0;
        endcase
    end

    assign out_port = live_r;
    assign irq      = irq_r;
endmodule

// File: tb/tb_led_color_fader.sv
// Directed bench for led_color_fader: a behavioural register/fade model is
// compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_led_color_fader;
    logic        clk;
    logic        reset;
    logic [23:0] out_port;
    logic        irq;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        run_chk  = 1'b0;

    led_color_fader_if bus_if();

    led_color_fader dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] live;
        logic [23:0] tgt;
        logic [15:0] period;
        logic [7:0]  step;
        logic [16:0] cnt;
        logic        done;
        logic        irq_en;
    } model_t;

    model_t m;

    // One clock of the fader behaviour in plain integer arithmetic
    function automatic model_t model_next(model_t c, logic rst, logic cs, logic wn,
                                          logic [1:0] a, logic [31:0] wd);
        model_t n;
        int ep, es, cu, t;
        bit wr, busy, snap, tw, set_done;
        if (rst) begin
            n = '0;
            n.period = 16'd50000;
            n.step   = 8'd1;
            return n;
        end
        n    = c;
        wr   = cs && !wn;
        tw   = wr && (a == 2'd0);
        snap = wr && (a == 2'd3) && wd[3];
        ep   = (c.period == 0) ? 1 : int'(c.period);
        es   = (c.step == 0) ? 1 : int'(c.step);
        busy = (c.live != c.tgt);
        set_done = 0;
        if (!busy) n.cnt = 0;
        else if (snap) begin
            n.live = c.tgt; n.cnt = 0; set_done = 1;
        end else if (tw) n.cnt = 0;
        else if (int'(c.cnt) + 1 >= ep) begin
            for (int k = 0; k < 3; k++) begin
                cu = int'(c.live[8*k +: 8]);
                t  = int'(c.tgt[8*k +: 8]);
                if (cu < t) cu = (cu + es < t) ? cu + es : t;
                else if (cu > t) cu = (cu - es > t) ? cu - es : t;
                n.live[8*k +: 8] = 8'(cu);
            end
            n.cnt = 0;
            set_done = (n.live == c.tgt);
        end else n.cnt = c.cnt + 17'd1;
        if (tw) n.tgt = wd[23:0];
        if (wr && a == 2'd1) n.period = wd[15:0];
        if (wr && a == 2'd2) n.step = wd[7:0];
        if (wr && a == 2'd3) n.irq_en = wd[2];
        if (set_done) n.done = 1'b1;
        else if (wr && a == 2'd3 && wd[1]) n.done = 1'b0;
        return n;
    endfunction

    function automatic logic [31:0] model_rd(model_t s, logic [1:0] a);
        case (a)
            2'd0:    return {8'd0, s.live};
            2'd1:    return {16'd0, s.period};
            2'd2:    return {24'd0, s.step};
            default: return {28'd0, 1'b0, s.irq_en, s.done, (s.live != s.tgt)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk)
        m <= model_next(m, reset, bus_if.chipselect, bus_if.write_n, bus_if.address, bus_if.writedata);

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("cyc_out_port", {8'd0, out_port}, {8'd0, m.live});
            chk("cyc_irq", {31'd0, irq}, {31'd0, m.done & m.irq_en});
            chk("cyc_readdata", bus_if.readdata, model_rd(m, bus_if.address));
        end
    end

    // All tasks start and end a couple of time units after a rising edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(posedge clk); #2;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus_if.address = a;
        #1;
        chk(name, bus_if.readdata, exp);
    endtask

    task automatic out_chk(input logic [23:0] exp, input string name);
        chk(name, {8'd0, out_port}, {8'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        wait_cyc(3);
        reset   = 1'b0;
        run_chk = 1'b1;

        // Reset values
        read_chk(2'd0, 32'h0, "rst_addr0");
        read_chk(2'd1, 32'd50000, "rst_addr1");
        read_chk(2'd2, 32'd1, "rst_addr2");
        read_chk(2'd3, 32'h0, "rst_addr3");
        out_chk(24'h0, "rst_out");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Ramp 0 -> 0x40FF00, period 4, step 0x10
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'h10);
        bus_write(2'd3, 32'h4);
        bus_write(2'd0, 32'h0040FF00);
        wait_cyc(3);
        out_chk(24'h000000, "ramp_before_first_step");
        wait_cyc(1);
        out_chk(24'h101000, "ramp_step1");
        chk("model_ramp_step1", {8'd0, m.live}, 32'h101000);
        wait_cyc(4);
        out_chk(24'h202000, "ramp_step2");
        wait_cyc(52);
        out_chk(24'h40F000, "ramp_step15");
        chk("ramp_irq_before_end", {31'd0, irq}, 32'd0);
        wait_cyc(4);
        out_chk(24'h40FF00, "ramp_final");
        chk("model_ramp_final", {8'd0, m.live}, 32'h40FF00);
        chk("ramp_irq_final", {31'd0, irq}, 32'd1);
        read_chk(2'd3, 32'h6, "ramp_status");
        bus_write(2'd3, 32'h6);
        chk("ramp_irq_cleared", {31'd0, irq}, 32'd0);

        // Period 0 and step 0xFF: single-step jumps
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'hFF);
        read_chk(2'd1, 32'h0, "period0_readback");
        bus_write(2'd0, 32'h00808080);
        wait_cyc(1);
        out_chk(24'h808080, "jump_808080");
        bus_write(2'd3, 32'h6);
        bus_write(2'd0, 32'h0000FF10);
        out_chk(24'h808080, "jump_not_yet");
        wait_cyc(1);
        out_chk(24'h00FF10, "jump_00FF10");
        chk("jump_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h0);
        chk("jump_irq_disabled", {31'd0, irq}, 32'd0);
        read_chk(2'd3, 32'h2, "jump_done_kept");
        bus_write(2'd3, 32'h2);

        // Mid-fade retarget, step 0 behaving as 1
        bus_write(2'd0, 32'h0);
        wait_cyc(1);
        bus_write(2'd3, 32'h2);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h000000FF);
        wait_cyc(20);
        out_chk(24'h00000A, "retarget_at_0A");
        read_chk(2'd3, 32'h1, "retarget_busy");
        bus_write(2'd0, 32'h0);
        wait_cyc(18);
        out_chk(24'h000001, "retarget_at_01");
        read_chk(2'd3, 32'h1, "retarget_no_early_done");
        wait_cyc(2);
        out_chk(24'h000000, "retarget_end");
        read_chk(2'd3, 32'h2, "retarget_done");
        bus_write(2'd3, 32'h2);

        // Snap
        bus_write(2'd1, 32'd100);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h00123456);
        wait_cyc(5);
        out_chk(24'h000000, "snap_before");
        bus_write(2'd3, 32'h8);
        out_chk(24'h123456, "snap_live");
        read_chk(2'd3, 32'h2, "snap_status");
        bus_write(2'd3, 32'h2);
        read_chk(2'd3, 32'h0, "snap_cleared");

        // done W1C on the same edge as the final step: set wins
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'hFF);
        bus_write(2'd0, 32'h0);
        wait_cyc(2);
        out_chk(24'h123456, "w1c_before_step");
        bus_write(2'd3, 32'h2);
        out_chk(24'h000000, "w1c_step");
        read_chk(2'd3, 32'h2, "w1c_set_wins");
        bus_write(2'd3, 32'h2);

        // Reset mid-fade at 0x303030
        bus_write(2'd3, 32'h4);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'h10);
        bus_write(2'd0, 32'h00606060);
        wait_cyc(6);
        out_chk(24'h303030, "midreset_live");
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        out_chk(24'h000000, "midreset_out");
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        read_chk(2'd1, 32'd50000, "midreset_period");
        read_chk(2'd2, 32'd1, "midreset_step");
        read_chk(2'd3, 32'h0, "midreset_status");
        wait_cyc(5);
        out_chk(24'h000000, "midreset_stays_idle");
        read_chk(2'd0, 32'h0, "midreset_addr0");

        wait_cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
